// File: rtl/fib_pwm_pkg.sv
// Shared types and helpers for the Fibonacci breathing PWM block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fib_pwm_pkg;

    // Breath direction: RISE walks up the Fibonacci ladder, FALL walks back down
    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } breath_state_e;

    // Counter offset for channel idx so channel edges are spread evenly over a period
    function automatic int phase_offset(input int idx, input int ch, input int w);
        return (idx * (1 << w)) / ch;
    endfunction

endpackage

// File: rtl/fib_pwm_channel.sv
// One PWM channel: phase-shifted counter view, period-aligned duty latch, registered compare.
// Latency: pwm_out follows the compare by one cycle; a new duty takes effect at the channel's own wrap.
// Backpressure: none; free-running while en is high.
module fib_pwm_channel
    import fib_pwm_pkg::*;
#(
    parameter int W   = 8,
    parameter int CH  = 4,
    parameter int IDX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ch_en,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty_in,
    output logic         pwm_out
);

    localparam logic [W-1:0] MAX    = {W{1'b1}};
    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] OFFSET = W'(phase_offset(IDX, CH, W));

    logic [W-1:0] ch_cnt;
    logic [W-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;

    // Channel view of the shared counter; natural W-bit wrap gives the modulo
    always_comb begin
        ch_cnt = cnt + OFFSET;
    end

    // Duty only changes at this channel's period boundary; disable restores the reset duty
    always_comb begin
        duty_d = duty_q;
        if (ch_cnt == MAX) begin
            duty_d = duty_in;
        end
        if (!en) begin
            duty_d = ONE;
        end
        pwm_d = en & ch_en & (ch_cnt < duty_q);
    end

    // Duty latch and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= ONE;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/fibonacci_breath_pwm_mc.sv
// Multi-channel breathing PWM whose shared duty walks the Fibonacci ladder up then down (FIB_PWM_ANTIPHASE_EN: odd channels use MAX+1-b).
// Latency: pwm_out registered, one cycle after the compare; breath step every HOLD periods.
// Backpressure: none; en=0 clears outputs and restarts everything on the next edge.
module fibonacci_breath_pwm_mc
    import fib_pwm_pkg::*;
#(
    parameter int W    = 8,
    parameter int CH   = 4,
    parameter int HOLD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] ch_en,
    output logic [CH-1:0] pwm_out,
    output logic [W-1:0]  duty_level,
    output logic          rising,
    output logic          peak_pulse
);

    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = W'(1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    breath_state_e state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          peak_q, peak_d;

    logic          wrap, upd, ovf, at_one, op_sub;
    logic [W:0]    alu;
    logic          unused_alu_msb;

    // Update strobe, overflow compare and the single shared add/subtract unit
    always_comb begin
        wrap   = (cnt_q == MAX);
        upd    = wrap && (hold_q == HW'(HOLD - 1));
        ovf    = (a_q > (MAX - b_q));
        at_one = (a_q == ONE) && (b_q == ONE);
        op_sub = 1'b0;
        case (state_q)
            RISE:    op_sub = ovf;
            FALL:    op_sub = !at_one;
            default: op_sub = 1'b0;
        endcase
        alu = op_sub ? ({1'b0, b_q} - {1'b0, a_q}) : ({1'b0, a_q} + {1'b0, b_q});
    end

    // The adder result never exceeds MAX in the step actually applied
    assign unused_alu_msb = alu[W];

    // Next state: turn at the top of the ladder and at the (1,1) floor
    always_comb begin
        state_d = state_q;
        if (upd) begin
            if (state_q == RISE && ovf) begin
                state_d = FALL;
            end else if (state_q == FALL && at_one) begin
                state_d = RISE;
            end
        end
        if (!en) begin
            state_d = RISE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RISE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM outputs
    always_comb begin
        rising = (state_q == RISE);
    end

    // Counter, hold counter and breath pair; subtract path is the falling step (b-a, a)
    always_comb begin
        cnt_d  = cnt_q + ONE;
        hold_d = hold_q;
        a_d    = a_q;
        b_d    = b_q;
        peak_d = 1'b0;
        if (wrap) begin
            hold_d = upd ? '0 : hold_q + HW'(1);
        end
        if (upd) begin
            if (op_sub) begin
                a_d = alu[W-1:0];
                b_d = a_q;
            end else begin
                a_d = b_q;
                b_d = alu[W-1:0];
            end
            peak_d = (state_q == RISE) && ovf;
        end
        if (!en) begin
            cnt_d  = '0;
            hold_d = '0;
            a_d    = ONE;
            b_d    = ONE;
            peak_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hold_q <= '0;
            a_q    <= ONE;
            b_q    <= ONE;
            peak_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            a_q    <= a_d;
            b_q    <= b_d;
            peak_q <= peak_d;
        end
    end

    assign duty_level = b_q;
    assign peak_pulse = peak_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] duty_in;
`ifdef FIB_PWM_ANTIPHASE_EN
        if (i % 2 == 1) begin : g_anti
            // MAX+1-b, which fits in W bits because b never drops below 1
            assign duty_in = {W{1'b0}} - b_q;
        end else begin : g_norm
            assign duty_in = b_q;
        end
`else
        assign duty_in = b_q;
`endif
        fib_pwm_channel #(
            .W   (W),
            .CH  (CH),
            .IDX (i)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .ch_en   (ch_en[i]),
            .cnt     (cnt_q),
            .duty_in (duty_in),
            .pwm_out (pwm_out[i])
        );
    end

endmodule
